// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES round-key buffer:
//   - key-length codes (KEY128/KEY192/KEY256, KEY_ILLEGAL)
//   - round counts per key length (NR_128/NR_192/NR_256)
//   - FSM state encoding for the buffer controller
//   - nr_of():    key-length code -> round count
//   - words_of(): round count -> number of expanded words, 4*(Nr+1)
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam logic [1:0] KEY128      = 2'b00;
  localparam logic [1:0] KEY192      = 2'b01;
  localparam logic [1:0] KEY256      = 2'b10;
  localparam logic [1:0] KEY_ILLEGAL = 2'b11;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_READ  = 2'd3
  } rk_state_e;

  // The illegal code never reaches LOAD, so its value here is irrelevant.
  function automatic logic [3:0] nr_of(input logic [1:0] key_lenth);
    logic [3:0] nr;
    case (key_lenth)
      KEY128:  nr = NR_128;
      KEY192:  nr = NR_192;
      KEY256:  nr = NR_256;
      default: nr = 4'd0;
    endcase
    return nr;
  endfunction

  // 4*(Nr+1): 44, 52 or 60 words.
  function automatic logic [5:0] words_of(input logic [3:0] nr);
    return {nr, 2'b00} + 6'd4;
  endfunction

endpackage

// File: rtl/aes_rk_mem.sv
// ---------------------------------------------------------------------------
// aes_rk_mem
// Round-key storage: DEPTH entries of 4*WORD_W bits.
// Ports:
//   clk, rst          clock; synchronous active-high reset (read register only)
//   we_i              write one WORD_W lane
//   wentry_i          entry (round index) being written
//   wlane_i           lane within entry; lane 0 is the most significant word
//   wdata_i           lane data
//   re_i              load the read register from raddr_i
//   raddr_i           read entry
//   rdata_o           registered read data; holds its value while re_i=0
// ---------------------------------------------------------------------------
module aes_rk_mem #(
  parameter int DEPTH  = 15,
  parameter int WORD_W = 32,
  parameter int AW     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [AW-1:0]         wentry_i,
  input  logic [1:0]            wlane_i,
  input  logic [WORD_W-1:0]     wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [4*WORD_W-1:0]   rdata_o
);

  logic [4*WORD_W-1:0] mem_q [DEPTH];
  logic [4*WORD_W-1:0] rdata_q;

  // Array contents are not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we_i) begin
      case (wlane_i)
        2'd0: mem_q[wentry_i][4*WORD_W-1 -: WORD_W] <= wdata_i;
        2'd1: mem_q[wentry_i][3*WORD_W-1 -: WORD_W] <= wdata_i;
        2'd2: mem_q[wentry_i][2*WORD_W-1 -: WORD_W] <= wdata_i;
        2'd3: mem_q[wentry_i][1*WORD_W-1 -: WORD_W] <= wdata_i;
      endcase
    end
  end

  // The read register doubles as the output register of the buffer, so it
  // only updates when a new key is to be presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/aes_rk_buffer.sv
// ---------------------------------------------------------------------------
// aes_rk_buffer
// Packs the expanded AES key schedule (32-bit words) into 128-bit round keys
// and replays them to the round datapath, ascending or descending, any
// number of times per load.
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   key_lenth             00/01/10 = AES-128/192/256, 11 illegal (on load_start)
//   load_start            start a new schedule load (aborts anything running)
//   wr_valid/wr_word      expanded-word stream, w[0] first
//   wr_ready              buffer accepts words (LOAD state)
//   load_done             full schedule stored
//   err                   one-cycle pulse on load_start with illegal key_lenth
//   rd_start/rd_dir       start a read pass; 0 = round 0..Nr, 1 = Nr..0
//   rd_valid/rd_ready     round-key handshake
//   rd_key                round key, w[4k] in [127:96]
//   rd_round              round index k of rd_key
//   rd_last               rd_key is the final key of this pass
// ---------------------------------------------------------------------------
module aes_rk_buffer
  import aes_pkg::*;
#(
  parameter int NR_MAX = 14,
  parameter int WORD_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          key_lenth,
  input  logic                load_start,
  input  logic                wr_valid,
  input  logic [WORD_W-1:0]   wr_word,
  output logic                wr_ready,
  output logic                load_done,
  output logic                err,
  input  logic                rd_start,
  input  logic                rd_dir,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [4*WORD_W-1:0] rd_key,
  output logic [3:0]          rd_round,
  output logic                rd_last
);

  rk_state_e  state_q, state_d;
  logic [3:0] nr_q, nr_d;
  logic [5:0] wcnt_q, wcnt_d;
  logic       dir_q, dir_d;
  logic [3:0] round_q, round_d;
  logic       rd_valid_q, rd_valid_d;
  logic       rd_last_q, rd_last_d;
  logic       err_q, err_d;

  logic       mem_we;
  logic       mem_re;
  logic [3:0] mem_raddr;
  logic [3:0] start_round;
  logic [3:0] next_round;

  aes_rk_mem #(
    .DEPTH  (NR_MAX + 1),
    .WORD_W (WORD_W),
    .AW     (4)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .we_i     (mem_we),
    .wentry_i (wcnt_q[5:2]),
    .wlane_i  (wcnt_q[1:0]),
    .wdata_i  (wr_word),
    .re_i     (mem_re),
    .raddr_i  (mem_raddr),
    .rdata_o  (rd_key)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      nr_q       <= '0;
      wcnt_q     <= '0;
      dir_q      <= 1'b0;
      round_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      nr_q       <= nr_d;
      wcnt_q     <= wcnt_d;
      dir_q      <= dir_d;
      round_q    <= round_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      err_q      <= err_d;
    end
  end

  assign start_round = rd_dir ? nr_q : 4'd0;
  assign next_round  = dir_q ? (round_q - 4'd1) : (round_q + 4'd1);

  // load_start outranks everything in every state; rd_start is only honoured
  // in READY, and a read handshake advances the pointer by one round. The
  // memory read register is loaded in the same cycle the pointer moves, which
  // keeps rd_key aligned with rd_round/rd_last.
  always_comb begin
    state_d    = state_q;
    nr_d       = nr_q;
    wcnt_d     = wcnt_q;
    dir_d      = dir_q;
    round_d    = round_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_raddr  = round_q;

    if (load_start) begin
      wcnt_d     = '0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      if (key_lenth == KEY_ILLEGAL) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        nr_d    = nr_of(key_lenth);
        state_d = ST_LOAD;
      end
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (wr_valid) begin
            mem_we = 1'b1;
            wcnt_d = wcnt_q + 6'd1;
            if (wcnt_q == words_of(nr_q) - 6'd1) begin
              state_d = ST_READY;
            end
          end
        end
        ST_READY: begin
          if (rd_start) begin
            dir_d      = rd_dir;
            round_d    = start_round;
            mem_re     = 1'b1;
            mem_raddr  = start_round;
            rd_valid_d = 1'b1;
            rd_last_d  = rd_dir ? (start_round == 4'd0) : (start_round == nr_q);
            state_d    = ST_READ;
          end
        end
        ST_READ: begin
          if (rd_ready) begin
            if (rd_last_q) begin
              rd_valid_d = 1'b0;
              rd_last_d  = 1'b0;
              state_d    = ST_READY;
            end else begin
              round_d   = next_round;
              mem_re    = 1'b1;
              mem_raddr = next_round;
              rd_last_d = dir_q ? (next_round == 4'd0) : (next_round == nr_q);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign wr_ready  = (state_q == ST_LOAD);
  assign load_done = (state_q == ST_READY) || (state_q == ST_READ);
  assign err       = err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign rd_round  = round_q;

endmodule

// File: doc/aes_rk_buffer.md
Name: aes_rk_buffer

Overview:
- Round-key buffer that sits directly downstream of the key-expansion stage.
- Accepts the expanded key schedule as a stream of 32-bit words w[0..4*(Nr+1)-1] and packs every four words into one 128-bit round key.
- Stores up to 15 round keys.
- Serves them to the cipher round datapath one per handshake: ascending order for encryption, descending order for decryption.
- Lets one expansion feed any number of encrypt/decrypt passes.

Parameters:
- NR_MAX, 14, largest supported round count; buffer depth is NR_MAX+1.
- WORD_W, 32, width of one expanded-key word.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- key_lenth  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=illegal; sampled only on load_start.
- load_start  in  1  pulse; begins a new schedule load.
- wr_valid  in  1  wr_word valid.
- wr_word  in  WORD_W  expanded word w[i], supplied in increasing i.
- wr_ready  out  1  buffer accepts a word.
- load_done  out  1  level; complete schedule stored.
- err  out  1  one-cycle pulse; load_start with key_lenth=11.
- rd_start  in  1  pulse; begins a read pass.
- rd_dir  in  1  0 = round 0..Nr, 1 = round Nr..0; sampled with rd_start.
- rd_valid  out  1  rd_key valid.
- rd_ready  in  1  consumer accepts rd_key.
- rd_key  out  128  round key; w[4k] in [127:96], w[4k+3] in [31:0].
- rd_round  out  4  round index k of rd_key.
- rd_last  out  1  rd_key is the final key of this pass.

Behaviour:
- Reset: state IDLE. wr_ready, load_done, err, rd_valid, rd_last = 0. rd_key = 0, rd_round = 0, all counters = 0. Buffer contents are don't-care.
- Nr is latched on load_start: 10, 12 or 14. Word total = 44, 52 or 60.
- States: IDLE, LOAD, READY, READ.
- IDLE:
  - load_start with legal key_lenth -> LOAD.
  - load_start with key_lenth=11 -> err=1 for one cycle, stay IDLE.
  - rd_start is ignored.
- load_start from any state:
  - Same rules as IDLE; it aborts any load or read in progress.
  - load_done, rd_valid and rd_last clear on the next edge.
  - Word counter resets to 0.
  - If key_lenth=11, the state goes to IDLE.
- LOAD:
  - wr_ready=1.
  - Each cycle with wr_valid & wr_ready writes word i to entry i>>2, lane i[1:0] (lane 0 = [127:96]); i increments.
  - On acceptance of word total-1 -> READY. wr_ready drops and load_done=1 from the next cycle.
  - rd_start is ignored.
- READY:
  - load_done=1.
  - rd_start -> READ; round pointer = 0 (rd_dir=0) or Nr (rd_dir=1).
  - The first rd_valid appears exactly one cycle after rd_start. The output is registered.
- READ:
  - rd_valid=1.
  - rd_key, rd_round and rd_last are held stable while rd_ready=0.
  - On rd_valid & rd_ready the next key is presented in the following cycle, so back-to-back transfers run at 1 key/cycle.
  - rd_last=1 on round Nr (ascending) or round 0 (descending).
  - A handshake with rd_last=1 -> READY, with rd_valid=0 next cycle. Contents are retained, so repeated passes are allowed.
  - rd_start during READ is ignored.
- Priority when events coincide: rst > load_start > rd_start > data handshakes.
- A wr_valid outside LOAD is dropped (wr_ready=0).
- Pointer range: the pointer stays within 0..Nr. No wrap is possible because the pass terminates at rd_last.

Decomposition:
- Shared package aes_pkg holds:
  - key-length codes KEY128/KEY192/KEY256;
  - constants NR_128=10, NR_192=12, NR_256=14;
  - function nr_of(key_lenth);
  - state encoding.
- One sub-module, aes_rk_mem:
  - (NR_MAX+1) x 128 register array;
  - 32-bit lane-write port (entry, lane, data, we);
  - one synchronous 128-bit read port.

Test Plan:
- AES-128 FIPS-197 key 000102..0f: stream its 44 expanded words, then rd_start with rd_dir=0.
  - Round 0 = 000102030405060708090a0b0c0d0e0f.
  - Round 10 = 13111d7fe3944a17f307a78b4d2b30c5, with rd_last=1.
  - load_done rises the cycle after word 43.
- AES-256, word i = i, rd_dir=1, rd_ready tied 1.
  - 15 consecutive rd_valid cycles: round 14 = {32'd56,57,58,59} down to round 0 = {0,1,2,3}.
  - rd_last only on round 0.
- AES-192, word i = i, rd_dir=0, rd_ready toggling 1010…
  - 13 keys delivered in order, held stable while rd_ready=0.
  - Round 12 = {48,49,50,51}.
- load_start with key_lenth=11 -> err pulse; state IDLE; wr_ready=0.
  - A subsequent rd_start produces no rd_valid.
- Mid-read abort:
  - After 3 handshakes of an AES-128 pass, assert load_start (key_lenth=00) -> rd_valid=0 and load_done=0 next cycle; wr_ready=1.
  - Reload with words i+100 -> round 0 = {100,101,102,103}.
- load_start and rd_start in the same READY cycle -> LOAD entered; no rd_valid.
- rst asserted mid-LOAD -> all outputs 0; rd_start is ignored until a full reload completes.
